// File: rtl/bowling.sv
// bowling: ten-pin game scorer that records throws and sums one frame per clock on request
module bowling (
  input  logic       clock,
  input  logic       reset,
  input  logic       roll,
  input  logic       calculate_score,
  input  logic [3:0] pin_count,
  output logic [8:0] score
);
  logic [20:0][3:0] rolls_q;
  logic [31:0][3:0] ext;
  logic [4:0]       roll_count_q, roll_count_d;
  logic [8:0]       score_q, score_d;
  logic [3:0]       frame_idx_q, frame_idx_d;
  logic [4:0]       roll_idx_q, roll_idx_d, idx, nxt;
  logic             calc_q, start, wr, strike, spare;
  logic [3:0]       a, b, c;
  logic [5:0]       frame;
  // Zero padding lets bonus lookups past slot 20 read as 0 without bounds logic.
  assign ext    = {44'b0, rolls_q};
  assign start  = calculate_score && !calc_q;
  assign wr     = roll && !calculate_score && roll_count_q != 5'd21;
  assign idx    = start ? 5'd0 : roll_idx_q;
  assign a      = ext[idx];
  assign b      = ext[idx + 5'd1];
  assign c      = ext[idx + 5'd2];
  assign strike = a == 4'd10;
  assign spare  = ({1'b0, a} + {1'b0, b}) == 5'd10;
  assign frame  = strike ? 6'd10 + 6'(b) + 6'(c) : spare ? 6'd10 + 6'(c) : 6'(a) + 6'(b);
  assign nxt    = idx + (strike ? 5'd1 : 5'd2);
  assign roll_count_d = wr ? roll_count_q + 5'd1 : roll_count_q;
  assign score  = score_q;
  always_comb begin
    score_d     = score_q;
    frame_idx_d = frame_idx_q;
    roll_idx_d  = roll_idx_q;
    if (start) begin
      score_d     = 9'(frame);
      frame_idx_d = 4'd1;
      roll_idx_d  = nxt;
    end else if (calculate_score && frame_idx_q < 4'd10) begin
      score_d     = score_q + 9'(frame);
      frame_idx_d = frame_idx_q + 4'd1;
      roll_idx_d  = nxt;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rolls_q      <= '0;
      roll_count_q <= '0;
      score_q      <= '0;
      frame_idx_q  <= '0;
      roll_idx_q   <= '0;
      calc_q       <= 1'b0;
    end else begin
      if (wr) rolls_q[roll_count_q] <= pin_count > 4'd10 ? 4'd10 : pin_count;
      roll_count_q <= roll_count_d;
      score_q      <= score_d;
      frame_idx_q  <= frame_idx_d;
      roll_idx_q   <= roll_idx_d;
      calc_q       <= calculate_score;
    end
  end
endmodule

// File: tb/tb_bowling.sv
// tb_bowling: directed and randomized checks of the bowling scorer against a rule-level game model
module tb_bowling;
  logic       clock = 0;
  logic       reset = 0;
  logic       roll = 0;
  logic       calculate_score = 0;
  logic [3:0] pin_count = 0;
  logic [8:0] score;
  int errors = 0;
  int checks = 0;
  int mem[21];
  int cnt;
  int held;

  bowling dut (
    .clock(clock), .reset(reset), .roll(roll),
    .calculate_score(calculate_score), .pin_count(pin_count), .score(score)
  );

  always #5 clock = ~clock;

  function automatic int rd(int k);
    return (k < 21) ? mem[k] : 0;
  endfunction

  function automatic int model_score();
    int s = 0;
    int i = 0;
    for (int f = 0; f < 10; f++) begin
      if (rd(i) == 10) begin
        s += 10 + rd(i + 1) + rd(i + 2);
        i += 1;
      end else if (rd(i) + rd(i + 1) == 10) begin
        s += 10 + rd(i + 2);
        i += 2;
      end else begin
        s += rd(i) + rd(i + 1);
        i += 2;
      end
    end
    return s;
  endfunction

  task automatic check(input string tag, input int exp);
    checks++;
    assert (score === 9'(exp)) else begin
      errors++;
      $error("FAIL %s: score=%0d expected=%0d", tag, score, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 21; k++) mem[k] = 0;
    cnt = 0;
  endtask

  task automatic model_add(input int p);
    if (cnt < 21) begin
      mem[cnt] = (p > 10) ? 10 : p;
      cnt++;
    end
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clock);
    reset = 0;
    model_clear();
  endtask

  task automatic roll_one(input int p);
    roll = 1;
    pin_count = 4'(p);
    @(negedge clock);
    roll = 0;
    model_add(p);
  endtask

  task automatic calc_check(input string tag);
    calculate_score = 1;
    repeat (10) @(negedge clock);
    check(tag, model_score());
    calculate_score = 0;
    @(negedge clock);
  endtask

  initial begin
    model_clear();
    @(negedge clock);
    do_reset();
    check("reset", 0);
    calc_check("empty_game");

    do_reset();
    roll_one(8);
    for (int k = 0; k < 19; k++) roll_one(0);
    calc_check("single_8");
    check("single_8_const", 8);

    do_reset();
    roll_one(5); roll_one(5); roll_one(5);
    for (int k = 0; k < 17; k++) roll_one(0);
    calculate_score = 1;
    @(negedge clock);
    check("partial_first_frame", 15);
    calculate_score = 0;
    @(negedge clock);
    calc_check("spare");
    check("spare_const", 20);

    do_reset();
    roll_one(10); roll_one(3); roll_one(4);
    for (int k = 0; k < 16; k++) roll_one(0);
    calc_check("strike");
    check("strike_const", 24);

    do_reset();
    for (int k = 0; k < 12; k++) roll_one(10);
    calc_check("perfect");
    check("perfect_const", 300);

    do_reset();
    for (int k = 0; k < 20; k++) roll_one(1);
    calc_check("all_ones");
    check("all_ones_const", 20);

    // score persists across rolls after calculation drops
    roll_one(7);
    @(negedge clock);
    check("hold_after_roll", 20);

    // reset mid-calculation
    calculate_score = 1;
    repeat (5) @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    calculate_score = 0;
    model_clear();
    check("reset_mid_calc", 0);
    @(negedge clock);

    // saturation and 22nd roll ignored
    do_reset();
    for (int k = 0; k < 21; k++) roll_one(k % 3 == 0 ? 15 : 2);
    calc_check("saturate_full");
    held = model_score();
    roll_one(9);
    calc_check("roll22_ignored");
    check("roll22_const", held);

    // rolls while calculating are ignored
    do_reset();
    roll_one(3); roll_one(4);
    calculate_score = 1;
    roll = 1;
    pin_count = 4'd9;
    repeat (10) @(negedge clock);
    roll = 0;
    check("roll_during_calc", 7);
    calculate_score = 0;
    @(negedge clock);

    // roll held high for N cycles records N throws
    do_reset();
    roll = 1;
    pin_count = 4'd2;
    repeat (3) @(negedge clock);
    roll = 0;
    for (int k = 0; k < 3; k++) model_add(2);
    calc_check("roll_held");
    check("roll_held_const", 6);

    // randomized games: legal frames or arbitrary pin values
    for (int g = 0; g < 12; g++) begin
      int n;
      do_reset();
      if (g % 2 == 0) begin
        for (int f = 0; f < 10; f++) begin
          int x = $urandom_range(0, 10);
          roll_one(x);
          if (x != 10) roll_one($urandom_range(0, 10 - x));
          if (f == 9 && x == 10) begin
            roll_one($urandom_range(0, 10));
            roll_one($urandom_range(0, 10));
          end
        end
        if (cnt == 20 && mem[18] + mem[19] == 10) roll_one($urandom_range(0, 10));
      end else begin
        n = $urandom_range(0, 23);
        for (int k = 0; k < n; k++) roll_one($urandom_range(0, 15));
      end
      calc_check($sformatf("random_game_%0d", g));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
